lap_timer: RTL and testbench

LAP_TIMER -- requirements
Module: lap_timer

---
 rtl/lap_timer_pkg.sv | 23 ++
 rtl/lap_timer_cs_tick_gen.sv | 34 +++
 rtl/lap_timer.sv | 114 +++++++++++
 tb/tb_lap_timer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap timer: FSM states, time width, default parameters.
package lap_timer_pkg;

  localparam int unsigned TIME_W         = 16;
  localparam int unsigned LAP_W          = 4;
  localparam int unsigned TICK_DIV_DEF   = 650000;
  localparam int unsigned LAPS_TOTAL_DEF = 3;

  typedef logic [TIME_W-1:0] time_t;

  localparam time_t TIME_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RACING   = 2'd1,
    ST_FINISHED = 2'd2
  } state_e;

  function automatic time_t time_min(input time_t a, input time_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/lap_timer_cs_tick_gen.sv
// Centisecond divider: counts 0..TICK_DIV-1 while enabled, pulses tick on the wrap.
module cs_tick_gen
  import lap_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             wrap;

  // Tick is the wrap condition itself so the time count advances on the wrapping edge
  assign wrap = enable && !clear && (cnt_q == CNT_LAST);
  assign tick = wrap;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lap_timer.sv
// Race lap timer: validates finish-line crossings against checkpoints and tracks lap times.
module lap_timer
  import lap_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned LAPS_TOTAL = LAPS_TOTAL_DEF
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             race_start,
  input  logic             lap_finished,
  input  logic             checkpoints_passed,
  output logic             racing,
  output logic             race_finished,
  output logic [LAP_W-1:0] lap_count,
  output logic             lap_valid,
  output logic [TIME_W-1:0] cur_lap_cs,
  output logic [TIME_W-1:0] last_lap_cs,
  output logic [TIME_W-1:0] best_lap_cs
);

  state_e           state_q, state_d;
  logic             lf_q;
  logic             crossing;
  logic             lap_ok;
  logic             final_lap;
  logic             tick;
  logic             div_en;

  logic [LAP_W-1:0] lap_count_d;
  logic             lap_valid_d;
  time_t            cur_d;
  time_t            last_d;
  time_t            best_d;

  assign crossing  = lap_finished && !lf_q;
  // race_start takes precedence over a simultaneous crossing
  assign lap_ok    = (state_q == ST_RACING) && crossing && checkpoints_passed && !race_start;
  assign final_lap = (lap_count + LAP_W'(1)) == LAP_W'(LAPS_TOTAL);
  assign div_en    = (state_q == ST_RACING);

  cs_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .enable (div_en),
    .clear  (race_start),
    .tick   (tick)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (race_start) begin
      state_d = ST_RACING;
    end else if (lap_ok && final_lap) begin
      state_d = ST_FINISHED;
    end
  end

  // Next values of the timing registers; a counted lap beats a coincident tick
  always_comb begin
    lap_count_d = lap_count;
    lap_valid_d = 1'b0;
    cur_d       = cur_lap_cs;
    last_d      = last_lap_cs;
    best_d      = best_lap_cs;
    if (race_start) begin
      lap_count_d = '0;
      cur_d       = '0;
      last_d      = '0;
      best_d      = TIME_MAX;
    end else if (lap_ok) begin
      lap_count_d = lap_count + LAP_W'(1);
      lap_valid_d = 1'b1;
      cur_d       = '0;
      last_d      = cur_lap_cs;
      best_d      = time_min(best_lap_cs, cur_lap_cs);
    end else if ((state_q == ST_RACING) && tick && (cur_lap_cs != TIME_MAX)) begin
      cur_d = cur_lap_cs + TIME_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      lf_q          <= 1'b0;
      racing        <= 1'b0;
      race_finished <= 1'b0;
      lap_count     <= '0;
      lap_valid     <= 1'b0;
      cur_lap_cs    <= '0;
      last_lap_cs   <= '0;
      best_lap_cs   <= TIME_MAX;
    end else begin
      lf_q          <= lap_finished;
      racing        <= (state_d == ST_RACING);
      race_finished <= (state_d == ST_FINISHED);
      lap_count     <= lap_count_d;
      lap_valid     <= lap_valid_d;
      cur_lap_cs    <= cur_d;
      last_lap_cs   <= last_d;
      best_lap_cs   <= best_d;
    end
  end

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer with a scoreboard of expected lap results.
module tb_lap_timer;

  logic        pclk;
  logic        rst_n;
  logic        race_start;
  logic        lap_finished;
  logic        checkpoints_passed;
  logic        racing;
  logic        race_finished;
  logic [3:0]  lap_count;
  logic        lap_valid;
  logic [15:0] cur_lap_cs;
  logic [15:0] last_lap_cs;
  logic [15:0] best_lap_cs;

  typedef struct {
    logic [3:0]  cnt;
    logic [15:0] last;
    logic [15:0] best;
  } lap_exp_t;

  lap_exp_t sb_q[$];
  lap_exp_t e;

  int tests;
  int failed;
  int pulses;
  int p0;

  lap_timer #(
    .TICK_DIV   (4),
    .LAPS_TOTAL (2)
  ) dut (
    .pclk               (pclk),
    .rst_n              (rst_n),
    .race_start         (race_start),
    .lap_finished       (lap_finished),
    .checkpoints_passed (checkpoints_passed),
    .racing             (racing),
    .race_finished      (race_finished),
    .lap_count          (lap_count),
    .lap_valid          (lap_valid),
    .cur_lap_cs         (cur_lap_cs),
    .last_lap_cs        (last_lap_cs),
    .best_lap_cs        (best_lap_cs)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // lap_valid is high for a whole cycle, so one falling edge sees each pulse once
  always @(negedge pclk) if (lap_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_cur(input logic [15:0] v);
    for (int i = 0; i < 400; i++) begin
      if (cur_lap_cs === v) break;
      step();
    end
    chk("reach_cur", 32'(cur_lap_cs), 32'(v));
  endtask

  task automatic wait_lap_and_score();
    for (int i = 0; i < 4; i++) begin
      step();
      if (lap_valid === 1'b1) break;
    end
    chk("lap_valid_seen", 32'(lap_valid), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_count", 32'(lap_count), 32'(e.cnt));
      chk("sb_last", 32'(last_lap_cs), 32'(e.last));
      chk("sb_best", 32'(best_lap_cs), 32'(e.best));
    end else begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end
    chk("cur_restart", 32'(cur_lap_cs), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_racing"}, 32'(racing), 32'd0);
    chk({pfx, "_finished"}, 32'(race_finished), 32'd0);
    chk({pfx, "_lap_valid"}, 32'(lap_valid), 32'd0);
    chk({pfx, "_lap_count"}, 32'(lap_count), 32'd0);
    chk({pfx, "_cur"}, 32'(cur_lap_cs), 32'd0);
    chk({pfx, "_last"}, 32'(last_lap_cs), 32'd0);
    chk({pfx, "_best"}, 32'(best_lap_cs), 32'hFFFF);
  endtask

  initial begin
    tests = 0; failed = 0; pulses = 0;
    rst_n = 1'b0; race_start = 1'b0; lap_finished = 1'b0; checkpoints_passed = 1'b0;

    // Reset state
    repeat (3) step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // Start: racing next cycle, then 40 cycles at 4 pclk/cs gives 10 cs
    race_start = 1'b1;
    step();
    race_start = 1'b0;
    chk("start_racing", 32'(racing), 32'd1);
    chk("start_cur", 32'(cur_lap_cs), 32'd0);
    repeat (40) step();
    chk("cur_after_40", 32'(cur_lap_cs), 32'd10);

    // Crossing without checkpoints is ignored; 8 more cycles -> 48 total -> 12 cs
    checkpoints_passed = 1'b0;
    lap_finished = 1'b1;
    repeat (3) step();
    lap_finished = 1'b0;
    repeat (5) step();
    chk("nocp_pulses", 32'(pulses), 32'd0);
    chk("nocp_count", 32'(lap_count), 32'd0);
    chk("nocp_cur", 32'(cur_lap_cs), 32'd12);

    // First valid lap at 25 cs
    wait_cur(16'd25);
    checkpoints_passed = 1'b1;
    lap_finished = 1'b1;
    sb_q.push_back('{cnt: 4'd1, last: 16'd25, best: 16'd25});
    wait_lap_and_score();
    chk("lap1_racing", 32'(racing), 32'd1);
    lap_finished = 1'b0;
    step();
    chk("lap1_pulse_once", 32'(lap_valid), 32'd0);
    chk("lap1_pulses", 32'(pulses), 32'd1);

    // Second valid lap at 30 cs finishes the race
    wait_cur(16'd30);
    lap_finished = 1'b1;
    sb_q.push_back('{cnt: 4'd2, last: 16'd30, best: 16'd25});
    wait_lap_and_score();
    step();
    chk("fin_finished", 32'(race_finished), 32'd1);
    chk("fin_racing", 32'(racing), 32'd0);

    // Further crossing while finished changes nothing
    lap_finished = 1'b0;
    step();
    lap_finished = 1'b1;
    repeat (6) step();
    chk("post_pulses", 32'(pulses), 32'd2);
    chk("post_count", 32'(lap_count), 32'd2);
    chk("post_last", 32'(last_lap_cs), 32'd30);
    chk("post_best", 32'(best_lap_cs), 32'd25);
    chk("post_cur", 32'(cur_lap_cs), 32'd0);

    // Restart from FINISHED clears the record
    lap_finished = 1'b0;
    race_start = 1'b1;
    step();
    race_start = 1'b0;
    chk("re_racing", 32'(racing), 32'd1);
    chk("re_count", 32'(lap_count), 32'd0);
    chk("re_last", 32'(last_lap_cs), 32'd0);
    chk("re_best", 32'(best_lap_cs), 32'hFFFF);

    // lap_finished held 10 cycles yields exactly one lap
    wait_cur(16'd5);
    p0 = pulses;
    lap_finished = 1'b1;
    sb_q.push_back('{cnt: 4'd1, last: 16'd5, best: 16'd5});
    wait_lap_and_score();
    repeat (9) step();
    chk("hold_one_pulse", 32'(pulses - p0), 32'd1);

    // race_start coinciding with a valid crossing discards the crossing
    lap_finished = 1'b0;
    step();
    p0 = pulses;
    race_start = 1'b1;
    lap_finished = 1'b1;
    step();
    race_start = 1'b0;
    repeat (3) step();
    chk("coin_pulses", 32'(pulses - p0), 32'd0);
    chk("coin_count", 32'(lap_count), 32'd0);
    chk("coin_best", 32'(best_lap_cs), 32'hFFFF);

    // Asynchronous reset mid-lap
    lap_finished = 1'b0;
    wait_cur(16'd7);
    p0 = pulses;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    repeat (2) step();
    chk("arst_pulses", 32'(pulses - p0), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("rel_racing", 32'(racing), 32'd0);
    chk("rel_cur", 32'(cur_lap_cs), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
